mp_add_sequencer: RTL



---
 rtl/mp_add_pkg.sv | 26 ++
 rtl/mp_add_sequencer_if.sv | 34 +++
 rtl/add16_core.sv | 27 ++
 rtl/mp_add_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// Shared types for the multi-precision add/subtract sequencer and its word adder.
package mp_add_pkg;

  localparam int DEF_DW    = 16;
  localparam int DEF_WORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic sign;
    logic zero;
    logic parity;
    logic carry;
    logic overflow;
  } flags_t;

  // Signed overflow: both operands share a sign that the result does not.
  function automatic logic add_overflow(input logic x_msb, input logic y_msb, input logic w_msb);
    return (x_msb & y_msb & ~w_msb) | (~x_msb & ~y_msb & w_msb);
  endfunction

endpackage

// File: rtl/mp_add_sequencer_if.sv
// Request/result bundle between a requester and the multi-precision sequencer.
interface mp_add_sequencer_if
  import mp_add_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int WORDS = DEF_WORDS
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DW*WORDS-1:0]   a;
  logic [DW*WORDS-1:0]   b;
  logic                  sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW*WORDS-1:0]   sum;
  logic                  carry;
  logic                  overflow;
  logic                  sign;
  logic                  zero;
  logic                  parity;
  logic                  busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry, overflow, sign, zero, parity, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry, overflow, sign, zero, parity, busy
  );

endinterface

// File: rtl/add16_core.sv
// Combinational word adder with carry-in; also reports per-word zero and odd parity.
module add16_core
  import mp_add_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic [DW-1:0] s,
  output logic          cout,
  output logic          zero_w,
  output logic          par_w
);

  logic [DW:0] full_s;

  // Unsigned DW+1-bit add; par_w is the XOR of the word bits.
  always_comb begin
    full_s = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
    s      = full_s[DW-1:0];
    cout   = full_s[DW];
    zero_w = ~|full_s[DW-1:0];
    par_w  = ^full_s[DW-1:0];
  end

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: walks the operands LSW first through one
// word adder, chaining carry, then commits full-width status flags in a final cycle.
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                clk,
  input  logic                rst,
  mp_add_sequencer_if.slave   bus
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  // Index runs one past the top word: that extra step commits the flags.
  localparam int            IW     = $clog2(WORDS + 1);
  localparam logic [IW-1:0] COMMIT = IW'(WORDS);

  logic [1:0]                 state_r;
  logic [IW-1:0]              idx_r;
  logic [WORDS-1:0][DW-1:0]   opa_r;
  logic [WORDS-1:0][DW-1:0]   opb_r;
  logic [WORDS-1:0][DW-1:0]   sum_r;
  logic                       cin_r;
  logic                       zacc_r;
  logic                       pacc_r;
  logic                       out_valid_r;
  flags_t                     flags_r;

  logic [DW-1:0]              x_s;
  logic [DW-1:0]              y_s;
  logic [DW-1:0]              w_s;
  logic                       c_s;
  logic                       wz_s;
  logic                       wp_s;
  logic                       in_ready_s;
  flags_t                     flags_s;

  // Select the current operand words; out-of-range index feeds zeros.
  always_comb begin
    x_s = '0;
    y_s = '0;
    for (int i = 0; i < WORDS; i++) begin
      x_s = (idx_r == IW'(i)) ? opa_r[i] : x_s;
      y_s = (idx_r == IW'(i)) ? opb_r[i] : y_s;
    end
  end

  add16_core #(.DW(DW)) u_core (
    .a      (x_s),
    .b      (y_s),
    .cin    (cin_r),
    .s      (w_s),
    .cout   (c_s),
    .zero_w (wz_s),
    .par_w  (wp_s)
  );

  // Flags derived from the completed top word and the accumulators.
  always_comb begin
    flags_s.sign     = sum_r[WORDS-1][DW-1];
    flags_s.zero     = zacc_r;
    flags_s.parity   = ~pacc_r;
    flags_s.carry    = cin_r;
    flags_s.overflow = add_overflow(opa_r[WORDS-1][DW-1], opb_r[WORDS-1][DW-1],
                                    sum_r[WORDS-1][DW-1]);
  end

  // Sequencer state, operand capture, word-by-word result and flag commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      opa_r       <= '0;
      opb_r       <= '0;
      sum_r       <= '0;
      cin_r       <= 1'b0;
      zacc_r      <= 1'b0;
      pacc_r      <= 1'b0;
      out_valid_r <= 1'b0;
      flags_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_s) begin
            opa_r   <= bus.a;
            opb_r   <= bus.sub ? ~bus.b : bus.b;
            cin_r   <= bus.sub;
            idx_r   <= '0;
            zacc_r  <= 1'b1;
            pacc_r  <= 1'b0;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (idx_r == COMMIT) begin
            flags_r     <= flags_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            for (int i = 0; i < WORDS; i++) begin
              if (idx_r == IW'(i)) begin
                sum_r[i] <= w_s;
              end else begin
                sum_r[i] <= sum_r[i];
              end
            end
            cin_r  <= c_s;
            zacc_r <= zacc_r & wz_s;
            pacc_r <= pacc_r ^ wp_s;
            idx_r  <= idx_r + IW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // Held low during reset even though the state register already reads IDLE.
  assign in_ready_s    = (state_r == IDLE) & ~rst;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.carry     = flags_r.carry;
  assign bus.overflow  = flags_r.overflow;
  assign bus.sign      = flags_r.sign;
  assign bus.zero      = flags_r.zero;
  assign bus.parity    = flags_r.parity;
  assign bus.busy      = (state_r != IDLE);

endmodule
